// File: rtl/clock_pkg.sv
// Shared constants for the clock mode sequencer.
//   ST_*    : FSM state encodings, also driven out on the debug 'state' port
//   BTN_*   : bit positions of the front-panel buttons in the packed button vectors
//   NUM_BTN : number of debounced buttons
package clock_pkg;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_SET_TIME  = 2'd1;
    localparam logic [1:0] ST_SET_ALARM = 2'd2;
    localparam logic [1:0] ST_COMMIT    = 2'd3;

    localparam int NUM_BTN   = 6;
    localparam int BTN_MODE  = 0;
    localparam int BTN_OK    = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;

    // True for the two edit states, where navigation and the idle timer are live.
    function automatic logic is_set_state(input logic [1:0] st);
        return (st == ST_SET_TIME) || (st == ST_SET_ALARM);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one raw, asynchronous push button.
//   clk, reset : system clock, async active-high reset
//   btn        : raw button level
//   press      : 1-cycle pulse on each accepted rising edge of the debounced level
// A new level is accepted only after it has been seen on the synchroniser output
// for DEB_CYCLES consecutive cycles; any disagreement restarts the count.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1, sync2;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            // Registered edge detect: adds the final cycle of press latency.
            press   <= level & ~level_d;
            if (sync2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock: debounces the six front-panel buttons and
// runs the RUN / SET_TIME / SET_ALARM / COMMIT state machine.
//   clk, reset             : 100 MHz clock, async active-high reset
//   btn_*                  : raw buttons (mode, ok, left, right, up, down)
//   set_mod_time/alarm     : edit-mode levels to the time / alarm setting datapaths
//   left_p..down_p         : 1-cycle navigation pulses, only while editing
//   load_time / load_alarm : 1-cycle commit strobes, issued in COMMIT
//   state                  : current FSM state for debug/display
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int          DEB_CYCLES   = 1_000_000,
    parameter logic [31:0] IDLE_TIMEOUT = 32'd3_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_ok,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       set_mod_time,
    output logic       set_mod_alarm,
    output logic       left_p,
    output logic       right_p,
    output logic       up_p,
    output logic       down_p,
    output logic       load_time,
    output logic       load_alarm,
    output logic [1:0] state
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;
    logic [1:0]         state_n;
    logic [31:0]        idle_cnt, idle_cnt_n;
    logic               in_set, timeout;

    always_comb begin
        btn_raw            = '0;
        btn_raw[BTN_MODE]  = btn_mode;
        btn_raw[BTN_OK]    = btn_ok;
        btn_raw[BTN_LEFT]  = btn_left;
        btn_raw[BTN_RIGHT] = btn_right;
        btn_raw[BTN_UP]    = btn_up;
        btn_raw[BTN_DOWN]  = btn_down;
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[i]),
            .press (press[i])
        );
    end

    assign in_set  = is_set_state(state);
    // Any press in the same cycle (even a dropped one) counts as activity.
    assign timeout = in_set && (press == '0) && (idle_cnt == IDLE_TIMEOUT - 32'd1);

    // ok is tested before mode so a simultaneous ok+mode commits.
    always_comb begin
        state_n = state;
        case (state)
            ST_RUN: begin
                if (press[BTN_MODE]) state_n = ST_SET_TIME;
            end
            ST_SET_TIME: begin
                if (press[BTN_OK])        state_n = ST_COMMIT;
                else if (press[BTN_MODE]) state_n = ST_SET_ALARM;
                else if (timeout)         state_n = ST_RUN;
            end
            ST_SET_ALARM: begin
                if (press[BTN_OK])        state_n = ST_COMMIT;
                else if (press[BTN_MODE]) state_n = ST_RUN;
                else if (timeout)         state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    // Idle counter only runs inside an edit state; entering one (or any press) restarts it.
    always_comb begin
        idle_cnt_n = idle_cnt + 32'd1;
        if (!is_set_state(state_n) || (state_n != state) || (press != '0))
            idle_cnt_n = '0;
    end

    // Outputs are registered from the next state so they line up with 'state'.
    // In COMMIT the source state picks which set_mod level stays up with its strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_RUN;
            idle_cnt      <= '0;
            set_mod_time  <= 1'b0;
            set_mod_alarm <= 1'b0;
            load_time     <= 1'b0;
            load_alarm    <= 1'b0;
            left_p        <= 1'b0;
            right_p       <= 1'b0;
            up_p          <= 1'b0;
            down_p        <= 1'b0;
        end else begin
            state         <= state_n;
            idle_cnt      <= idle_cnt_n;
            set_mod_time  <= (state_n == ST_SET_TIME) ||
                             ((state_n == ST_COMMIT) && (state == ST_SET_TIME));
            set_mod_alarm <= (state_n == ST_SET_ALARM) ||
                             ((state_n == ST_COMMIT) && (state == ST_SET_ALARM));
            load_time     <= (state_n == ST_COMMIT) && (state == ST_SET_TIME);
            load_alarm    <= (state_n == ST_COMMIT) && (state == ST_SET_ALARM);
            // Opposing directions in the same cycle cancel each other.
            left_p        <= in_set && press[BTN_LEFT]  && !press[BTN_RIGHT];
            right_p       <= in_set && press[BTN_RIGHT] && !press[BTN_LEFT];
            up_p          <= in_set && press[BTN_UP]    && !press[BTN_DOWN];
            down_p        <= in_set && press[BTN_DOWN]  && !press[BTN_UP];
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl with DEB_CYCLES=4, IDLE_TIMEOUT=50.
// Stimulus pushes the expected output vector and the cycle it must appear in;
// a monitor pops and compares every time the observed output vector changes.
module tb_clock_mode_ctrl;
    import clock_pkg::*;

    localparam int          DEB  = 4;
    localparam logic [31:0] IDLE = 32'd50;

    // Observed vector: {state[1:0], smt, sma, left, right, up, down, load_t, load_a}
    localparam logic [9:0] V_RUN  = 10'b00_00_0000_00;
    localparam logic [9:0] V_ST   = 10'b01_10_0000_00;
    localparam logic [9:0] V_SA   = 10'b10_01_0000_00;
    localparam logic [9:0] V_CT   = 10'b11_10_0000_10;
    localparam logic [9:0] V_CA   = 10'b11_01_0000_01;
    localparam logic [9:0] V_ST_U = 10'b01_10_0010_00;
    localparam logic [9:0] V_ST_L = 10'b01_10_1000_00;

    localparam logic [5:0] M_MODE  = 6'b000001;
    localparam logic [5:0] M_OK    = 6'b000010;
    localparam logic [5:0] M_LEFT  = 6'b000100;
    localparam logic [5:0] M_RIGHT = 6'b001000;
    localparam logic [5:0] M_UP    = 6'b010000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_mode = 1'b0, btn_ok = 1'b0, btn_left = 1'b0;
    logic btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic set_mod_time, set_mod_alarm, left_p, right_p, up_p, down_p;
    logic load_time, load_alarm;
    logic [1:0] state;
    logic [9:0] obs;

    clock_mode_ctrl #(.DEB_CYCLES(DEB), .IDLE_TIMEOUT(IDLE)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_mode      (btn_mode),
        .btn_ok        (btn_ok),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .set_mod_time  (set_mod_time),
        .set_mod_alarm (set_mod_alarm),
        .left_p        (left_p),
        .right_p       (right_p),
        .up_p          (up_p),
        .down_p        (down_p),
        .load_time     (load_time),
        .load_alarm    (load_alarm),
        .state         (state)
    );

    assign obs = {state, set_mod_time, set_mod_alarm, left_p, right_p, up_p, down_p,
                  load_time, load_alarm};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [9:0] v;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int up_press_cnt = 0;
    logic cnt_en = 1'b0;

    task automatic exp_at(input int c, input logic [9:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [5:0] m);
        btn_mode  = m[BTN_MODE];
        btn_ok    = m[BTN_OK];
        btn_left  = m[BTN_LEFT];
        btn_right = m[BTN_RIGHT];
        btn_up    = m[BTN_UP];
        btn_down  = m[BTN_DOWN];
    endtask

    task automatic do_press(input logic [5:0] m, input int hold, input int gap);
        set_btn(m);
        tick(hold);
        set_btn(6'b0);
        tick(gap);
    endtask

    task automatic check_vec(input string name, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Monitor: every change of the observed vector must match the head of the queue.
    initial begin
        logic [9:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (obs !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got=%b want=no change", cyc, obs);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.v !== obs) begin
                        errors++;
                        $display("FAIL event cyc=%0d got=%b want cyc=%0d %b", cyc, obs, e.c, e.v);
                    end
                end
                prev = obs;
            end
        end
    end

    // Counts internal up presses after the final reset release.
    initial begin
        forever begin
            @(negedge clk);
            if (cnt_en && dut.g_btn[BTN_UP].u_deb.press) up_press_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=no finish want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        #1 reset = 1'b1;
        #1 check_vec("reset_outputs", obs, V_RUN);
        tick(3);
        reset = 1'b0;
        tick(5);

        // 1: mode press enters SET_TIME 8 cycles after the button goes high; glitch ignored.
        c = cyc; exp_at(c + 8, V_ST);
        do_press(M_MODE, 10, 12);
        do_press(M_MODE, 3, 12);

        // 2: ok commits time for exactly one cycle.
        c = cyc; exp_at(c + 8, V_CT); exp_at(c + 9, V_RUN);
        do_press(M_OK, 10, 12);

        // 3: mode x3 cycles RUN -> SET_TIME -> SET_ALARM -> RUN.
        c = cyc; exp_at(c + 8, V_ST);  do_press(M_MODE, 10, 12);
        c = cyc; exp_at(c + 8, V_SA);  do_press(M_MODE, 10, 12);
        c = cyc; exp_at(c + 8, V_RUN); do_press(M_MODE, 10, 12);

        // 4: nav in SET_TIME: up, left, then left+right cancel; then nothing in RUN.
        c = cyc; exp_at(c + 8, V_ST); do_press(M_MODE, 10, 12);
        c = cyc; exp_at(c + 8, V_ST_U); exp_at(c + 9, V_ST); do_press(M_UP, 10, 12);
        c = cyc; exp_at(c + 8, V_ST_L); exp_at(c + 9, V_ST); do_press(M_LEFT, 10, 12);
        do_press(M_LEFT | M_RIGHT, 10, 12);
        c = cyc; exp_at(c + 8, V_SA);  do_press(M_MODE, 10, 12);
        c = cyc; exp_at(c + 8, V_RUN); do_press(M_MODE, 10, 12);
        do_press(M_UP, 10, 12);
        do_press(M_LEFT, 10, 12);
        do_press(M_LEFT | M_RIGHT, 10, 12);

        // 5: idle timeout in SET_ALARM (50 cycles after entry), then ok+mode commits alarm.
        c = cyc; exp_at(c + 8, V_ST); do_press(M_MODE, 10, 12);
        c = cyc; exp_at(c + 8, V_SA); exp_at(c + 58, V_RUN);
        do_press(M_MODE, 10, 12);
        tick(45);
        c = cyc; exp_at(c + 8, V_ST); do_press(M_MODE, 10, 12);
        c = cyc; exp_at(c + 8, V_SA); do_press(M_MODE, 10, 12);
        c = cyc; exp_at(c + 8, V_CA); exp_at(c + 9, V_RUN);
        do_press(M_OK | M_MODE, 10, 12);

        // 6: async reset mid-edit with up bouncing; up held through release -> one press, no up_p.
        c = cyc; exp_at(c + 8, V_ST); do_press(M_MODE, 10, 12);
        check_vec("in_set_time", obs, V_ST);
        btn_up = 1'b1; tick(2);
        btn_up = 1'b0; tick(1);
        btn_up = 1'b1; tick(2);
        btn_up = 1'b0; tick(1);
        btn_up = 1'b1; tick(1);
        #2;
        exp_at(cyc, V_RUN);
        reset = 1'b1;
        #1 check_vec("async_reset_outputs", obs, V_RUN);
        tick(3);
        reset = 1'b0;
        cnt_en = 1'b1;
        tick(25);
        btn_up = 1'b0;
        tick(12);
        checks++;
        if (up_press_cnt != 1) begin
            errors++;
            $display("FAIL held_up_presses got=%0d want=1", up_press_cnt);
        end
        check_vec("final_outputs", obs, V_RUN);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d pending want=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
